// File: rtl/io_arb_pkg.sv
// Shared types and constants for the IO register-window arbiter.
package io_arb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [31:0] IO_SEG_ADDR    = 32'hFFFF_F000;
  localparam logic [31:0] IO_LED_ADDR    = 32'hFFFF_F004;
  localparam logic [31:0] IO_KEY_ADDR    = 32'hFFFF_F008;
  localparam logic [31:0] IO_BUTTON_ADDR = 32'hFFFF_F012;

  localparam logic [19:0] IO_BASE_HI_DEF = 20'hFFFFF;
endpackage

// File: rtl/io_bus_arbiter_rr.sv
// Combinational two-way round-robin picker; zero latency.
// Masked requesters are ignored; on a tie the master that did not win last time is chosen.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  input  logic [1:0] mask_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);
  logic [1:0] eff_req;

  assign eff_req     = req_i & ~mask_i;
  assign gnt_valid_o = |eff_req;
  assign gnt_idx_o   = (&eff_req) ? ~last_grant_i : eff_req[1];
endmodule

// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter for the IO window; req sampled in cycle 0, io_ce cycle 1, ack cycle 2.
// Masters hold req until ack; IO_BUS_ARBITER_LOCK_EN adds m*_lock for back-to-back locked re-grants.
module io_bus_arbiter
  import io_arb_pkg::*;
#(
  parameter int          AW         = 32,
  parameter int          DW         = 32,
  parameter logic [19:0] IO_BASE_HI = IO_BASE_HI_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic          m0_err,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [DW-1:0] m1_rdata,
  output logic          io_ce,
  output logic          io_we,
  output logic [AW-1:0] io_addr,
  output logic [DW-1:0] io_wdata,
  input  logic [DW-1:0] io_rdata
`ifdef IO_BUS_ARBITER_LOCK_EN
  ,
  input  logic          m0_lock,
  input  logic          m1_lock
`endif
);
  state_e        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_grant_q, last_grant_d;
  logic          err_pend_q, err_pend_d;
  logic          io_ce_q, io_ce_d, io_we_q, io_we_d;
  logic [AW-1:0] io_addr_q, io_addr_d;
  logic [DW-1:0] io_wdata_q, io_wdata_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic [DW-1:0] cap_rdata;
  logic [1:0]    req, lock, mask;
  logic          pick_vld, pick_idx;
  logic          load, load_idx, lg_upd;

  assign req = {m1_req, m0_req};
`ifdef IO_BUS_ARBITER_LOCK_EN
  assign lock = {m1_lock, m0_lock};
`else
  assign lock = 2'b00;
`endif

  // In RESP the master being acked is masked so a held req counts as a fresh request.
  assign mask = (state_q == RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;

  rr_arb2 u_rr (
    .req_i       (req),
    .last_grant_i(last_grant_q),
    .mask_i      (mask),
    .gnt_valid_o (pick_vld),
    .gnt_idx_o   (pick_idx)
  );

  assign cap_rdata = (io_ce_q && !io_we_q) ? io_rdata : '0;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    err_pend_d   = err_pend_q;
    io_ce_d      = 1'b0;
    io_we_d      = 1'b0;
    io_addr_d    = '0;
    io_wdata_d   = '0;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    load         = 1'b0;
    load_idx     = pick_idx;
    lg_upd       = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          load   = 1'b1;
          lg_upd = 1'b1;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (gnt_q) m1_rdata_d = cap_rdata;
        else       m0_rdata_d = cap_rdata;
      end
      RESP: begin
        if (lock[gnt_q] && req[gnt_q]) begin
          load     = 1'b1;
          load_idx = gnt_q;
        end else if (pick_vld) begin
          load   = 1'b1;
          lg_upd = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d = ACCESS;
      gnt_d   = load_idx;
      if (lg_upd) last_grant_d = load_idx;
      if (load_idx) begin
        io_we_d    = m1_we;
        io_addr_d  = m1_addr;
        io_wdata_d = m1_wdata;
      end else begin
        io_we_d    = m0_we;
        io_addr_d  = m0_addr;
        io_wdata_d = m0_wdata;
      end
      io_ce_d    = (io_addr_d[AW-1 -: 20] == IO_BASE_HI);
      err_pend_d = !io_ce_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      err_pend_q   <= 1'b0;
      io_ce_q      <= 1'b0;
      io_we_q      <= 1'b0;
      io_addr_q    <= '0;
      io_wdata_q   <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      err_pend_q   <= err_pend_d;
      io_ce_q      <= io_ce_d;
      io_we_q      <= io_we_d;
      io_addr_q    <= io_addr_d;
      io_wdata_q   <= io_wdata_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  assign m0_ack   = (state_q == RESP) && !gnt_q;
  assign m1_ack   = (state_q == RESP) && gnt_q;
  assign m0_err   = m0_ack && err_pend_q;
  assign m1_err   = m1_ack && err_pend_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign io_ce    = io_ce_q;
  assign io_we    = io_we_q;
  assign io_addr  = io_addr_q;
  assign io_wdata = io_wdata_q;
endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: directed cycle checks plus randomized two-master traffic,
// with a scoreboard monitor comparing every ack and slave access against a transaction model.
module tb_io_bus_arbiter;
  import io_arb_pkg::*;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_v[2], we_v[2], lock_v[2];
  logic [31:0] addr_v[2], wdata_v[2];
  logic        ack_w[2], err_w[2];
  logic [31:0] rdata_w[2];
  logic        io_ce, io_we;
  logic [31:0] io_addr, io_wdata, io_rdata;

  int   nvec = 0;
  int   nerr = 0;
  rsp_t exp_q[2][$];
  acc_t sq[2][$];

  always #5 clk = ~clk;

  function automatic logic [31:0] slave_f(input logic [31:0] a);
    if (a == IO_BUTTON_ADDR) return 32'h1234_5678;
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_3C3C;
  endfunction

  assign io_rdata = slave_f(io_addr);

  io_bus_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .m0_req  (req_v[0]),
    .m0_we   (we_v[0]),
    .m0_addr (addr_v[0]),
    .m0_wdata(wdata_v[0]),
    .m0_ack  (ack_w[0]),
    .m0_err  (err_w[0]),
    .m0_rdata(rdata_w[0]),
    .m1_req  (req_v[1]),
    .m1_we   (we_v[1]),
    .m1_addr (addr_v[1]),
    .m1_wdata(wdata_v[1]),
    .m1_ack  (ack_w[1]),
    .m1_err  (err_w[1]),
    .m1_rdata(rdata_w[1]),
    .io_ce   (io_ce),
    .io_we   (io_we),
    .io_addr (io_addr),
    .io_wdata(io_wdata),
    .io_rdata(io_rdata)
`ifdef IO_BUS_ARBITER_LOCK_EN
    ,
    .m0_lock (lock_v[0]),
    .m1_lock (lock_v[1])
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Transaction-level model: out-of-window -> err, reads return slave data, writes read 0.
  task automatic issue(input int m, input logic we, input logic [31:0] a, input logic [31:0] d);
    rsp_t r;
    acc_t s;
    logic inwin;
    inwin   = (a[31:12] == IO_BASE_HI_DEF);
    r.err   = !inwin;
    r.rdata = (inwin && !we) ? slave_f(a) : 32'h0;
    exp_q[m].push_back(r);
    if (inwin) begin
      s.we = we; s.addr = a; s.wdata = d;
      sq[m].push_back(s);
    end
    we_v[m] = we; addr_v[m] = a; wdata_v[m] = d; req_v[m] = 1'b1;
  endtask

  // Monitor / scoreboard
  logic        rst_s;
  logic [31:0] last_rd[2];
  logic        prev_ce;
  bit          mon_en = 1'b0;
  rsp_t        mon_r;
  bit          matched;

  always @(posedge clk) rst_s <= rst;

  always @(negedge clk) begin
    if (rst_s || !mon_en) begin
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;
      prev_ce    = 1'b0;
    end else begin
      chk("ack_exclusive", 32'(ack_w[0] & ack_w[1]), 32'h0);
      for (int m = 0; m < 2; m++) begin
        if (ack_w[m]) begin
          if (exp_q[m].size() == 0) begin
            nvec++; nerr++;
            $display("FAIL m%0d_unexpected_ack: ack=1, want no ack (nothing pending)", m);
          end else begin
            mon_r = exp_q[m].pop_front();
            chk($sformatf("m%0d_err", m), 32'(err_w[m]), 32'(mon_r.err));
            chk($sformatf("m%0d_rdata", m), rdata_w[m], mon_r.rdata);
            last_rd[m] = mon_r.rdata;
          end
        end else begin
          chk($sformatf("m%0d_rdata_hold", m), rdata_w[m], last_rd[m]);
        end
      end
      if (io_ce) begin
        chk("io_ce_window", 32'(io_addr[31:12]), 32'(IO_BASE_HI_DEF));
        chk("io_ce_spacing", 32'(prev_ce), 32'h0);
        matched = 1'b0;
        for (int m = 0; m < 2; m++) begin
          if (!matched && sq[m].size() > 0 && sq[m][0].we == io_we &&
              sq[m][0].addr == io_addr && sq[m][0].wdata == io_wdata) begin
            void'(sq[m].pop_front());
            matched = 1'b1;
          end
        end
        nvec++;
        if (!matched) begin
          nerr++;
          $display("FAIL slave_access: got we=%0b addr=%h wdata=%h, want a pending master access",
                   io_we, io_addr, io_wdata);
        end
      end
      prev_ce = io_ce;
    end
  end

  task automatic drv(input int m, input int n);
    logic [31:0] a;
    logic        got;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) step();
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[31:12] = IO_BASE_HI_DEF;
      else if (a[31:12] == IO_BASE_HI_DEF) a[31] = 1'b0;
      issue(m, 1'($urandom_range(0, 1)), a, $urandom);
      got = 1'b0;
      for (int k = 0; k < 6 && !got; k++) begin
        step();
        got = ack_w[m];
      end
      nvec++;
      if (!got) begin
        nerr++;
        $display("FAIL m%0d_ack_latency: no ack within 6 cycles, want ack", m);
      end
      req_v[m] = 1'b0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      req_v[m] = 1'b0; we_v[m] = 1'b0; lock_v[m] = 1'b0;
      addr_v[m] = 32'h0; wdata_v[m] = 32'h0;
    end
    repeat (3) step();
    chk("rst_io_ce", 32'(io_ce), 32'h0);
    chk("rst_io_we", 32'(io_we), 32'h0);
    chk("rst_io_addr", io_addr, 32'h0);
    chk("rst_io_wdata", io_wdata, 32'h0);
    chk("rst_acks", {30'h0, ack_w[1], ack_w[0]}, 32'h0);
    chk("rst_errs", {30'h0, err_w[1], err_w[0]}, 32'h0);
    chk("rst_m0_rdata", rdata_w[0], 32'h0);
    chk("rst_m1_rdata", rdata_w[1], 32'h0);
    rst = 1'b0;
    mon_en = 1'b1;
    step();

    // Contention from reset: m0 first, m1 straight from RESP, third contention back to m0.
    issue(0, 1'b1, IO_SEG_ADDR, 32'h0000_0011);
    issue(1, 1'b0, IO_LED_ADDR, 32'h0000_0022);
    step(); chk("c1_addr_m0", io_addr, IO_SEG_ADDR);
    step(); chk("c2_m0_ack", 32'(ack_w[0]), 32'h1); req_v[0] = 1'b0;
    step(); chk("c3_m1_ce", 32'(io_ce), 32'h1); chk("c3_addr_m1", io_addr, IO_LED_ADDR);
    step(); chk("c4_m1_ack", 32'(ack_w[1]), 32'h1); req_v[1] = 1'b0;
    step();
    issue(0, 1'b0, IO_KEY_ADDR, 32'h0000_0033);
    issue(1, 1'b1, IO_BUTTON_ADDR, 32'h0000_0044);
    step(); chk("c3rd_addr_m0", io_addr, IO_KEY_ADDR);
    step(); chk("c3rd_m0_ack", 32'(ack_w[0]), 32'h1); req_v[0] = 1'b0;
    step(); chk("c3rd_addr_m1", io_addr, IO_BUTTON_ADDR);
    step(); chk("c3rd_m1_ack", 32'(ack_w[1]), 32'h1); req_v[1] = 1'b0;
    step();

    // m0 write to LED
    issue(0, 1'b1, IO_LED_ADDR, 32'h0000_ABCD);
    step();
    chk("wr_io_ce", 32'(io_ce), 32'h1);
    chk("wr_io_we", 32'(io_we), 32'h1);
    chk("wr_io_wdata", io_wdata, 32'h0000_ABCD);
    step();
    chk("wr_m0_ack", 32'(ack_w[0]), 32'h1);
    chk("wr_m0_err", 32'(err_w[0]), 32'h0);
    req_v[0] = 1'b0;
    step();

    // m1 read BUTTON
    issue(1, 1'b0, IO_BUTTON_ADDR, 32'h0);
    step(); chk("rd_io_we", 32'(io_we), 32'h0);
    step();
    chk("rd_m1_ack", 32'(ack_w[1]), 32'h1);
    chk("rd_m0_ack", 32'(ack_w[0]), 32'h0);
    chk("rd_m1_rdata", rdata_w[1], 32'h1234_5678);
    req_v[1] = 1'b0;
    step();

    // m0 out-of-window read
    issue(0, 1'b0, 32'h0000_1000, 32'h0);
    step(); chk("oow_io_ce", 32'(io_ce), 32'h0);
    step();
    chk("oow_m0_ack", 32'(ack_w[0]), 32'h1);
    chk("oow_m0_err", 32'(err_w[0]), 32'h1);
    chk("oow_m0_rdata", rdata_w[0], 32'h0);
    req_v[0] = 1'b0;
    step();

    // Reset during an m1 read's ACCESS cycle
    issue(1, 1'b0, IO_KEY_ADDR, 32'h0);
    step();
    rst = 1'b1; req_v[1] = 1'b0;
    step();
    chk("rmid_m1_ack", 32'(ack_w[1]), 32'h0);
    chk("rmid_io_ce", 32'(io_ce), 32'h0);
    chk("rmid_io_addr", io_addr, 32'h0);
    chk("rmid_m1_rdata", rdata_w[1], 32'h0);
    chk("rmid_m0_rdata", rdata_w[0], 32'h0);
    chk("rmid_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;
    exp_q[1].delete();
    sq[1].delete();
    step();

`ifdef IO_BUS_ARBITER_LOCK_EN
    // Locked m0 holds the bus for two accesses before m1 is served.
    lock_v[0] = 1'b1;
    issue(0, 1'b1, IO_LED_ADDR, 32'h0000_00A5);
    issue(1, 1'b0, IO_KEY_ADDR, 32'h0);
    step(); chk("lk_addr1", io_addr, IO_LED_ADDR);
    step(); chk("lk_ack1", 32'(ack_w[0]), 32'h1);
    issue(0, 1'b1, IO_SEG_ADDR, 32'h0000_005A);
    step(); chk("lk_addr2", io_addr, IO_SEG_ADDR);
    step(); chk("lk_ack2", 32'(ack_w[0]), 32'h1);
    req_v[0] = 1'b0; lock_v[0] = 1'b0;
    step(); chk("lk_m1_addr", io_addr, IO_KEY_ADDR);
    step(); chk("lk_m1_ack", 32'(ack_w[1]), 32'h1);
    req_v[1] = 1'b0;
    step();
`endif

    fork
      drv(0, 200);
      drv(1, 200);
    join
    repeat (4) step();
    chk("m0_pending_left", 32'(exp_q[0].size()), 32'h0);
    chk("m1_pending_left", 32'(exp_q[1].size()), 32'h0);
    chk("slave_pending_left", 32'(sq[0].size() + sq[1].size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/io_bus_arbiter.md
# io_bus_arbiter

Two-master arbiter for the memory-mapped IO register block (SEG, LED, KEY, BUTTON window at 0xFFFFF000–0xFFFFFFFF). It shares the single IO slave port between the CPU data port (master 0) and the debug/UART bridge (master 1). Each access uses a registered request/acknowledge handshake with round-robin fairness. Out-of-window addresses are rejected with an error acknowledge, and the slave is never touched for them.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- IO_BASE_HI, 20'hFFFFF, required value of addr[31:12] for an in-window access

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- m0_req / m1_req  in  1  access request; held until the matching ack
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  AW  byte address
- m0_wdata / m1_wdata  in  DW  write data
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- m0_err / m1_err  out  1  high together with ack for out-of-window address
- m0_rdata / m1_rdata  out  DW  read data, valid while ack is high, held afterwards
- io_ce  out  1  slave chip enable
- io_we  out  1  slave write enable
- io_addr  out  AW  slave address
- io_wdata  out  DW  slave write data
- io_rdata  in  DW  slave combinational read data

## Operation
- FSM states:
  - IDLE: no transaction.
  - ACCESS: slave bus driven for the granted master.
  - RESP: ack pulse to the granted master.
- IDLE with any req high → ACCESS.
  - Winner is chosen by rr picker.
  - Winner's we, addr and wdata are registered onto io_* outputs.
  - io_ce = 1 only if addr[31:12] == IO_BASE_HI; otherwise io_ce = 0 and err_pending is set.
- ACCESS → RESP unconditionally.
  - The slave write takes effect at the edge ending ACCESS.
  - io_rdata is captured into the winner's rdata register at that edge; 0 on error or write.
  - io_ce, io_we, io_addr and io_wdata return to 0.
- RESP:
  - Winner's ack = 1; err = err_pending.
  - Arbitration considers only the other master. If its req is high → ACCESS for it; else → IDLE.
  - A master that keeps req high through its own ack is treated as issuing a new request, granted from IDLE at the earliest.
- Round-robin:
  - last_grant register, reset to 1, so m0 wins the first contention.
  - On simultaneous requests in IDLE, the master ≠ last_grant wins.
  - last_grant updates on entry to ACCESS.
- Non-granted master's ack, err and rdata stay unchanged (ack 0).

## Timing
- Request sampled in cycle 0 (IDLE) → io_ce in cycle 1 → ack in cycle 2.
  - Single-master throughput: one access per 3 cycles.
  - Alternating masters: one access per 2 cycles.
- Reset values: state IDLE; last_grant = 1; io_ce, io_we = 0; io_addr, io_wdata = 0; all ack, err = 0; all rdata = 0.
- Reset mid-transaction: the transaction is dropped with no ack. A write already committed at the ACCESS edge is not undone.
- req dropped before ack is a protocol violation. The arbiter completes the access regardless.

## Configuration
- IO_BUS_ARBITER_LOCK_EN defined: adds m0_lock and m1_lock (in, 1).
  - If the granted master has lock = 1 and req = 1 during RESP, the next state is ACCESS for the same master, and the other master is ignored.
  - Lock releases as soon as lock or req is low in RESP.
  - last_grant is not updated on locked re-grants. Used for atomic read-modify-write of LED/SEG.
- Undefined: lock ports absent; behaviour exactly as in Operation.

## Structure
- Shared package io_arb_pkg:
  - State encoding: IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2.
  - IO address constants: SEG 0xFFFFF000, LED 0xFFFFF004, KEY 0xFFFFF008, BUTTON 0xFFFFF012.
  - IO_BASE_HI default.
- Sub-module rr_arb2: combinational two-way round-robin picker.
  - Inputs: req[1:0], last_grant, mask[1:0].
  - Outputs: gnt_valid, gnt_idx.

## Test plan
- m0 write 0x0000ABCD to 0xFFFFF004 at cycle 0 → io_ce = 1, io_we = 1, io_wdata = 0x0000ABCD in cycle 1; m0_ack = 1, m0_err = 0 in cycle 2.
- m1 read 0xFFFFF012, slave returns 0x12345678 → m1_rdata = 0x12345678 with m1_ack in cycle 2; m0_ack stays 0.
- Both req from reset → m0 granted first; m1 io_ce in cycle 3 (directly from RESP), m1_ack in cycle 4; third contention goes to m0.
- m0 read 0x00001000 → io_ce never asserted; m0_ack = 1, m0_err = 1, m0_rdata = 0 in cycle 2.
- rst asserted in cycle 1 of an m1 read → no m1_ack; all outputs 0 the next cycle; state IDLE.
- With IO_BUS_ARBITER_LOCK_EN, m0_lock = 1 and both requesting → m0 granted for two consecutive accesses (acks at cycles 2 and 4); m1 granted only after m0_lock drops.
